// File: rtl/booth_product_bcd.sv
// Signed two's-complement product to sign + packed BCD magnitude converter.
// Double-dabble, one magnitude bit per clock, valid/ready on both sides.
module booth_product_bcd #(
    parameter int W  = 8,
    parameter int ND = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    product,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_sign,
    output logic [4*ND-1:0] out_bcd
);

    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    mag;
    logic [4*ND-1:0] bcd;
    logic [4*ND-1:0] bcd_adj;
    logic [4*ND-1:0] bcd_next;
    logic            sign_r;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Add-3 correction on every digit that would overflow past 9 after doubling
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < ND; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_next = {bcd_adj[4*ND-2:0], mag[W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mag      <= '0;
            bcd      <= '0;
            sign_r   <= 1'b0;
            out_sign <= 1'b0;
            out_bcd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r <= product[W-1];
                        // The most negative input negates to itself, which reads as 2^(W-1) unsigned
                        mag    <= product[W-1] ? (~product + W'(1)) : product;
                        bcd    <= '0;
                        cnt    <= CW'(W);
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= bcd_next;
                    mag <= {mag[W-2:0], 1'b0};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        out_bcd  <= bcd_next;
                        out_sign <= sign_r;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_product_bcd.sv
// Directed-vector bench for booth_product_bcd: table of conversions plus
// backpressure, back-to-back streaming and mid-conversion reset sequences.
module tb_booth_product_bcd;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  product;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [11:0] out_bcd;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  product;
        logic        exp_sign;
        logic [11:0] exp_bcd;
    } vec_t;

    vec_t vecs[8];

    booth_product_bcd #(.W(8), .ND(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sign  (out_sign),
        .out_bcd   (out_bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one product for exactly one edge
    task automatic applyStimulus(input logic [7:0] p);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
        product  = p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [11:0] held_bcd;
        logic [7:0]  stream[4];
        logic        s_sign[4];
        logic [11:0] s_bcd[4];
        int          acc_cyc[4];
        int          acc_idx;
        int          res_idx;
        int          cyc;
        logic        accept_now;

        vecs[0] = '{8'h0F, 1'b0, 12'h015};
        vecs[1] = '{8'hC8, 1'b1, 12'h056};
        vecs[2] = '{8'h40, 1'b0, 12'h064};
        vecs[3] = '{8'h80, 1'b1, 12'h128};
        vecs[4] = '{8'h7F, 1'b0, 12'h127};
        vecs[5] = '{8'h00, 1'b0, 12'h000};
        vecs[6] = '{8'hFF, 1'b1, 12'h001};
        vecs[7] = '{8'h25, 1'b0, 12'h037};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        product   = 8'h00;
        #12;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out_sign", 32'(out_sign), 32'd0);
        checkOutput("reset_out_bcd", 32'(out_bcd), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] table vectors");
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b1;
            applyStimulus(vecs[i].product);
            checkOutput($sformatf("v%0d_not_valid_at_accept", i), 32'(out_valid), 32'd0);
            waitResult(lat);
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'd8);
            checkOutput($sformatf("v%0d_sign", i), 32'(out_sign), 32'(vecs[i].exp_sign));
            checkOutput($sformatf("v%0d_bcd", i), 32'(out_bcd), 32'(vecs[i].exp_bcd));
            checkOutput($sformatf("v%0d_busy_in_done", i), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_valid_falls", i), 32'(out_valid), 32'd0);
            checkOutput($sformatf("v%0d_back_idle", i), 32'(in_ready), 32'd1);
        end

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(8'hC6);
        waitResult(lat);
        checkOutput("bp_latency", 32'(lat), 32'd8);
        checkOutput("bp_sign", 32'(out_sign), 32'd1);
        checkOutput("bp_bcd", 32'(out_bcd), 32'h058);
        held_bcd = out_bcd;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            product  = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            checkOutput($sformatf("bp_hold_valid_%0d", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_hold_in_ready_%0d", k), 32'(in_ready), 32'd0);
            checkOutput($sformatf("bp_hold_bcd_%0d", k), 32'(out_bcd), 32'(held_bcd));
            checkOutput($sformatf("bp_hold_sign_%0d", k), 32'(out_sign), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        checkOutput("bp_no_second_accept", 32'(in_ready), 32'd1);

        $display("[TB] back-to-back stream");
        stream[0] = 8'h0F; s_sign[0] = 1'b0; s_bcd[0] = 12'h015;
        stream[1] = 8'hC8; s_sign[1] = 1'b1; s_bcd[1] = 12'h056;
        stream[2] = 8'h80; s_sign[2] = 1'b1; s_bcd[2] = 12'h128;
        stream[3] = 8'h7F; s_sign[3] = 1'b0; s_bcd[3] = 12'h127;
        acc_idx   = 0;
        res_idx   = 0;
        cyc       = 0;
        product   = stream[0];
        out_ready = 1'b1;
        while (res_idx < 4 && cyc < 100) begin
            in_valid   = (acc_idx < 4);
            accept_now = in_ready && (acc_idx < 4);
            @(posedge clk); #1;
            cyc++;
            if (accept_now) begin
                if (acc_idx > 0)
                    checkOutput($sformatf("b2b_interval_%0d", acc_idx), 32'(cyc - acc_cyc[acc_idx-1]), 32'd10);
                acc_cyc[acc_idx] = cyc;
                acc_idx++;
                if (acc_idx < 4) product = stream[acc_idx];
            end
            if (out_valid && res_idx < acc_idx) begin
                checkOutput($sformatf("b2b_latency_%0d", res_idx), 32'(cyc - acc_cyc[res_idx]), 32'd8);
                checkOutput($sformatf("b2b_sign_%0d", res_idx), 32'(out_sign), 32'(s_sign[res_idx]));
                checkOutput($sformatf("b2b_bcd_%0d", res_idx), 32'(out_bcd), 32'(s_bcd[res_idx]));
                res_idx++;
            end
        end
        in_valid = 1'b0;
        checkOutput("b2b_result_count", 32'(res_idx), 32'd4);
        @(posedge clk); #1;

        $display("[TB] reset mid-conversion");
        out_ready = 1'b1;
        applyStimulus(8'h5A);
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("rst_mid_busy", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_mid_out_bcd", 32'(out_bcd), 32'd0);
        checkOutput("rst_mid_out_sign", 32'(out_sign), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h25);
        waitResult(lat);
        checkOutput("rst_fresh_latency", 32'(lat), 32'd8);
        checkOutput("rst_fresh_sign", 32'(out_sign), 32'd0);
        checkOutput("rst_fresh_bcd", 32'(out_bcd), 32'h037);
        @(posedge clk); #1;
        checkOutput("rst_fresh_idle", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
